// File: rtl/decode_writeback.sv
// ----------------------------------------------------------------------------
// decode_writeback
//
// SEQ-processor decode / write-back stage. It turns fetch's icode/rA/rB into
// resolved register IDs, reads two operands combinationally from a 15-entry
// register file, and commits execute's valE and memory's valM at the clock
// edge.
//
// Ports:
//   clk      system clock, all state updates on posedge
//   rst      synchronous active-high reset (clears every register)
//   icode    instruction code from fetch
//   rA, rB   register specifiers from fetch (15 = none)
//   cnd      condition flag from execute, gates the cmovXX destination
//   valE     ALU result to be written to dstE
//   valM     memory data to be written to dstM
//   wb_en    write-back enable
//   srcA/srcB/dstE/dstM  resolved register IDs (15 = none)
//   valA/valB            register file reads of srcA/srcB (ID 15 reads 0)
//   dbg_sel / dbg_val    debug read port (ID 15 reads 0)
// ----------------------------------------------------------------------------
module decode_writeback #(
    parameter int WIDTH  = 64,
    parameter int NREGS  = 15,
    parameter int RSP_ID = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    input  logic             wb_en,
    output logic [3:0]       srcA,
    output logic [3:0]       srcB,
    output logic [3:0]       dstE,
    output logic [3:0]       dstM,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    input  logic [3:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_val
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'(RSP_ID);

    // Instruction codes
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // ------------------------------------------------------------------
    // Register ID resolution
    // ------------------------------------------------------------------
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            I_RRMOVQ: begin
                srcA = rA;
                // cmovXX with a failed condition writes nothing
                dstE = cnd ? rB : RNONE;
            end
            I_IRMOVQ: begin
                dstE = rB;
            end
            I_RMMOVQ: begin
                srcA = rA;
                srcB = rB;
            end
            I_MRMOVQ: begin
                srcB = rB;
                dstM = rA;
            end
            I_OPQ: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            I_CALL: begin
                srcB = RSP;
                dstE = RSP;
            end
            I_RET: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
            end
            I_PUSHQ: begin
                srcA = rA;
                srcB = RSP;
                dstE = RSP;
            end
            I_POPQ: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
                dstM = rA;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    // 16-entry view so every 4-bit ID has a defined read value; slot 15 is 0
    logic [WIDTH-1:0] rd_view [16];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_next
            // dstM is checked first so popq %rsp keeps the popped value.
            // ID 15 never matches a register index, so those writes vanish.
            assign regs_d[gi] = !wb_en                ? regs_q[gi] :
                                (dstM == 4'(gi))      ? valM       :
                                (dstE == 4'(gi))      ? valE       :
                                                        regs_q[gi];
        end

        for (gi = 0; gi < 16; gi++) begin : g_view
            if (gi < NREGS) begin : g_real
                assign rd_view[gi] = regs_q[gi];
            end else begin : g_none
                assign rd_view[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads see pre-edge contents; there is deliberately no write bypass.
    assign valA    = rd_view[srcA];
    assign valB    = rd_view[srcB];
    assign dbg_val = rd_view[dbg_sel];

endmodule
